// File: rtl/bss_pkg.sv
//------------------------------------------------------------------------------
// Module  : bss_pkg
// Brief   : Shared state encoding and default width for the bit-serial subtractor.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bss_pkg;

  localparam int BSS_WIDTH = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bss_seq_if.sv
//------------------------------------------------------------------------------
// Module  : bss_seq_if
// Brief   : start/done handshake and operand/result bus; BSS_SIGNED_OVF_EN adds ovf.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface bss_seq_if
  import bss_pkg::*;
#(
  parameter int WIDTH = BSS_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
  logic             done;

`ifdef BSS_SIGNED_OVF_EN
  logic             ovf;

  modport master (output start, a, b, input diff, bout, busy, done, ovf);
  modport slave  (input start, a, b, output diff, bout, busy, done, ovf);
`else
  modport master (output start, a, b, input diff, bout, busy, done);
  modport slave  (input start, a, b, output diff, bout, busy, done);
`endif

endinterface

`default_nettype wire

// File: rtl/bss_seq_fs_bit.sv
//------------------------------------------------------------------------------
// Module  : fs_bit
// Brief   : Combinational 1-bit full subtractor (x - y - bin).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fs_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bin;
  assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

`default_nettype wire

// File: rtl/bss_seq.sv
//------------------------------------------------------------------------------
// Module  : bss_seq
// Brief   : Bit-serial subtractor diff = a - b, LSB first, with final borrow.
//           Optional macro BSS_SIGNED_OVF_EN adds a signed-overflow output.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bss_seq
  import bss_pkg::*;
#(
  parameter int WIDTH = BSS_WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  bss_seq_if.slave bus
);

  localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_diff;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_br;
  logic               r_bout;
  logic               r_busy;
  logic               r_done;
  logic               w_d;
  logic               w_bo;
  logic               w_load;
  logic               w_last;

  fs_bit u_fs_bit (
    .x   (r_sa[0]),
    .y   (r_sb[0]),
    .bin (r_br),
    .d   (w_d),
    .bo  (w_bo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == c_cnt_last) begin
          w_last      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // busy/done come from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_acc  <= '0;
      r_diff <= '0;
      r_cnt  <= '0;
      r_br   <= 1'b0;
      r_bout <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= (w_state_nxt == ST_DONE);
      if (w_load) begin
        r_sa  <= bus.a;
        r_sb  <= bus.b;
        r_acc <= '0;
        r_br  <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == ST_SHIFT) begin
        r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
        r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
        r_acc <= {w_d, r_acc[WIDTH-1:1]};
        r_br  <= w_bo;
        r_cnt <= r_cnt + c_cnt_one;
        if (w_last) begin
          r_diff <= {w_d, r_acc[WIDTH-1:1]};
          r_bout <= w_bo;
        end
      end
    end
  end

`ifdef BSS_SIGNED_OVF_EN
  logic r_ovf;

  // In the last SHIFT cycle bit 0 of each operand register holds its sign bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= (r_sa[0] != r_sb[0]) && (w_d != r_sa[0]);
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_bss_seq.sv
//------------------------------------------------------------------------------
// Module  : tb_bss_seq
// Brief   : Self-checking bench for bss_seq (vector table plus corner sequences).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bss_seq;
  import bss_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bss_seq_if #(.WIDTH(W)) bus ();

  bss_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  vec_t       vecs [10];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] prev_diff;
  logic       prev_bout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_op(input int id, input vec_t v);
    int   lat;
    int   nbusy;
    logic held_ok;
    lat     = 0;
    nbusy   = 0;
    held_ok = 1'b1;
    @(negedge clk);
    bus.a     = v.a;
    bus.b     = v.b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.done) lat = k;
      else if (bus.diff !== prev_diff || bus.bout !== prev_bout) held_ok = 1'b0;
    end
    chk($sformatf("v%0d_latency", id), lat, 9);
    chk($sformatf("v%0d_hold_prev", id), 32'(held_ok), 1);
    chk($sformatf("v%0d_diff", id), 32'(bus.diff), 32'(v.diff));
    chk($sformatf("v%0d_bout", id), 32'(bus.bout), 32'(v.bout));
`ifdef BSS_SIGNED_OVF_EN
    chk($sformatf("v%0d_ovf", id), 32'(bus.ovf), 32'(v.ovf));
`endif
    @(negedge clk);
    chk($sformatf("v%0d_busy_cycles", id), nbusy, 9);
    chk($sformatf("v%0d_idle_after", id), {30'd0, bus.busy, bus.done}, 0);
    prev_diff = v.diff;
    prev_bout = v.bout;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] exp2;
    int         ndone;
    logic       done9;
    logic       done19;
    logic       idle10;
    logic       no_done_rst;

    //         a       b       diff    bout  ovf
    vecs[0] = '{8'd34,  8'd15,  8'd19,  1'b0, 1'b0};
    vecs[1] = '{8'd15,  8'd34,  8'd237, 1'b1, 1'b0};
    vecs[2] = '{8'd129, 8'd129, 8'd0,   1'b0, 1'b0};
    vecs[3] = '{8'd0,   8'd1,   8'd255, 1'b1, 1'b0};
    vecs[4] = '{8'd0,   8'd255, 8'd1,   1'b1, 1'b0};
    vecs[5] = '{8'd255, 8'd0,   8'd255, 1'b0, 1'b0};
    vecs[6] = '{8'd128, 8'd1,   8'd127, 1'b0, 1'b1};
    vecs[7] = '{8'd100, 8'd50,  8'd50,  1'b0, 1'b0};
    vecs[8] = '{8'd127, 8'd255, 8'd128, 1'b1, 1'b1};
    vecs[9] = '{8'd255, 8'd255, 8'd0,   1'b0, 1'b0};

    rst       = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {21'd0, bus.diff, bus.bout, bus.busy, bus.done}, 0);
`ifdef BSS_SIGNED_OVF_EN
    chk("reset_ovf", 32'(bus.ovf), 0);
`endif
    rst = 1'b1;
    prev_diff = 8'd0;
    prev_bout = 1'b0;

    for (int i = 0; i < 10; i++) run_op(i, vecs[i]);

    // start held high while operands churn every cycle
    ndone  = 0;
    done9  = 1'b0;
    done19 = 1'b0;
    idle10 = 1'b0;
    ra     = 8'd0;
    rb     = 8'd0;
    exp2   = 8'd0;
    @(negedge clk);
    bus.a     = 8'd200;
    bus.b     = 8'd55;
    bus.start = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (k == 9) begin
          done9 = 1'b1;
          chk("held_start_diff1", 32'(bus.diff), 145);
          chk("held_start_bout1", 32'(bus.bout), 0);
        end
        if (k == 19) begin
          done19 = 1'b1;
          chk("held_start_diff2", 32'(bus.diff), 32'(exp2));
          chk("held_start_bout2", 32'(bus.bout), 32'(ra < rb));
        end
      end
      if (k == 10) idle10 = ~bus.busy;
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      if (k == 10) begin
        ra   = bus.a;
        rb   = bus.b;
        exp2 = ra - rb;
      end
    end
    bus.start = 1'b0;
    chk("held_start_done_count", ndone, 2);
    chk("held_start_done_at_9_19", {30'd0, done9, done19}, 3);
    chk("held_start_idle_gap", 32'(idle10), 1);
    @(negedge clk);
    prev_diff = exp2;
    prev_bout = (ra < rb);

    // asynchronous reset in the 4th SHIFT cycle
    @(negedge clk);
    bus.a     = 8'd50;
    bus.b     = 8'd20;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", 32'(bus.busy), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_reset_outputs", {21'd0, bus.diff, bus.bout, bus.busy, bus.done}, 0);
`ifdef BSS_SIGNED_OVF_EN
    chk("mid_reset_ovf", 32'(bus.ovf), 0);
`endif
    no_done_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) no_done_rst = 1'b0;
    end
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) no_done_rst = 1'b0;
    end
    chk("reset_abort_no_done", 32'(no_done_rst), 1);
    prev_diff = 8'd0;
    prev_bout = 1'b0;
    run_op(10, '{8'd10, 8'd3, 8'd7, 1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bss_seq.md
Name: bss_seq

Overview:
- Bit-serial subtractor: computes diff = a - b (unsigned, modulo 2^WIDTH) one bit per clock, LSB first, plus a final borrow.
- Sequential counterpart to the team's bit-serial adder.
- Uses the same start/done handshake as the sequential GCD control path, so either can be driven by a common controller.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      asynchronous active-low reset (rst=0 resets; released synchronously by the environment)
- start  input   1      request; sampled only in IDLE
- a      input   WIDTH  minuend; captured on the accepting edge
- b      input   WIDTH  subtrahend; captured on the accepting edge
- diff   output  WIDTH  result register; holds the last result until the next accepted start
- bout   output  1      final borrow: 1 when a < b unsigned
- busy   output  1      high in SHIFT and DONE
- done   output  1      one-cycle pulse in DONE; diff and bout are valid from this cycle on

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - diff=0, bout=0, busy=0, done=0.
  - Internal shift registers, borrow flip-flop and counter cleared.
- States: IDLE=0, SHIFT=1, DONE=2. Encoding value 3 is unreachable and returns to IDLE.
- IDLE:
  - start=1 at an edge: load sa<=a, sb<=b, br<=0, cnt<=0; go to SHIFT.
  - diff and bout are not cleared on load; they keep their old values until the DONE edge.
- SHIFT, each edge:
  - d = sa[0] ^ sb[0] ^ br
  - br <= (~sa[0] & sb[0]) | (~(sa[0]^sb[0]) & br)
  - sa and sb shift right by one, zero fill.
  - An internal accumulator shifts right with d entering the MSB.
  - cnt <= cnt+1. cnt width is $clog2(WIDTH+1).
  - When cnt==WIDTH-1: go to DONE; diff <= final accumulator; bout <= borrow out of the MSB.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency:
  - start accepted at edge N gives done=1 in the cycle after edge N+WIDTH.
  - Back-to-back throughput is one operation per WIDTH+2 cycles.
- start is ignored in SHIFT and DONE. a and b may change freely after the accepting edge.
- start held high continuously re-launches from each IDLE cycle.
- Reset asserted mid-SHIFT aborts the operation with no done pulse; every output returns to its reset value.
- Boundaries:
  - a==b gives diff=0, bout=0.
  - a=0, b=2^WIDTH-1 gives diff=1, bout=1.
  - Wrap-around is modulo 2^WIDTH.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: BSS_SIGNED_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), reset value 0.
  - Registered on the DONE transition with the two's-complement overflow: (a_msb != b_msb) && (d_msb != a_msb).
  - a_msb and b_msb are the operand MSBs as they reach bit 0 in the last SHIFT cycle; d_msb is the final d.
  - Held with diff.
- Undefined: ovf port and its logic are absent; interface and behaviour otherwise identical.

Decomposition:
- Shared package bss_pkg:
  - state localparams S_IDLE, S_SHIFT, S_DONE (2-bit).
  - default width constant BSS_WIDTH=8.
- One natural sub-module: fs_bit, a combinational 1-bit full subtractor (x, y, bin -> d, bo).
- The FSM, counter and shift registers stay in bss_seq.

Test Plan:
- a=34, b=15, start pulse in IDLE -> done pulses 9 cycles after the accepting edge; diff=19, bout=0, busy high exactly 9 cycles.
- a=15, b=34 -> diff=237, bout=1. Then a=129, b=129 -> diff=0, bout=0, with the previous diff=237 held until that DONE edge.
- a=0, b=1 -> diff=255, bout=1. With BSS_SIGNED_OVF_EN: a=128, b=1 -> diff=127, ovf=1; a=100, b=50 -> diff=50, ovf=0.
- start held high, a/b changed every cycle during SHIFT (first operands a=200, b=55) -> result diff=145; the new operation starts only after DONE; exactly one done per operation.
- rst=0 asynchronously at the 4th SHIFT cycle -> diff=0, bout=0, busy=0, done=0 immediately with no done pulse; after release, a=10, b=3 -> diff=7 with normal 9-cycle latency.
